// File: rtl/rtp_result_collector.sv
// Merges per-core traversal hits into one FWFT stream.
// Also tracks run length, per-core finish and completion/timeout.
module rtp_result_collector #(
    parameter int NUM_CH         = 2,
    parameter int DATA_W         = 32,
    parameter int FIFO_DEPTH     = 16,
    parameter int CNT_W          = 64,
    parameter int TIMEOUT_CYCLES = 1048576,
    localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     io_start,
    input  logic [NUM_CH-1:0]        io_ch_valid,
    output logic [NUM_CH-1:0]        io_ch_ready,
    input  logic [NUM_CH*DATA_W-1:0] io_ch_ray_id,
    input  logic [NUM_CH*DATA_W-1:0] io_ch_hitT,
    input  logic [NUM_CH-1:0]        io_ch_finish,
    output logic                     io_out_valid,
    input  logic                     io_out_ready,
    output logic [DATA_W-1:0]        io_out_ray_id,
    output logic [DATA_W-1:0]        io_out_hitT,
    output logic [CH_W-1:0]          io_out_ch,
    output logic [CNT_W-1:0]         io_total_cycle,
    output logic [31:0]              io_result_count,
    output logic                     io_busy,
    output logic                     io_all_done,
    output logic                     io_timeout
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 2 * DATA_W + CH_W;

    typedef enum logic [2:0] {
        S_IDLE, S_RUN, S_DRAIN, S_DONE, S_TIMEOUT
    } state_t;

    state_t              state;
    logic [NUM_CH-1:0]   fin_q;
    logic [CH_W-1:0]     rr_q;
    logic [CNT_W-1:0]    total_q;
    logic [31:0]         res_cnt_q;
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]       count;
    logic [EW-1:0]       mem [FIFO_DEPTH];

    logic                active, full, empty, arb_en, push, pop;
    logic                found, all_fin, timeout_hit, can_start;
    logic [CH_W-1:0]     grant, gidx, rr_next;
    logic [EW-1:0]       head;
    int                  idx;

    assign active    = (state == S_RUN) || (state == S_DRAIN);
    assign can_start = (state == S_IDLE) || (state == S_DONE) ||
                       (state == S_TIMEOUT);
    assign full      = (count == CW'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign arb_en    = active && !full;

    // First valid core at or after the round-robin pointer.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        gidx  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx  = (int'(rr_q) + k) % NUM_CH;
            gidx = CH_W'(idx);
            if (!found && io_ch_valid[gidx]) begin
                found = 1'b1;
                grant = gidx;
            end
        end
    end

    assign push    = arb_en && found;
    assign pop     = !empty && io_out_ready;
    assign rr_next = (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
    assign io_ch_ready = push ? (NUM_CH'(1) << grant) : '0;

    assign all_fin     = &(fin_q | io_ch_finish);
    assign timeout_hit = (total_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            fin_q     <= '0;
            rr_q      <= '0;
            total_q   <= '0;
            res_cnt_q <= '0;
        end else begin
            if (active && total_q != '1)
                total_q <= total_q + 1'b1;
            if (push) begin
                res_cnt_q <= res_cnt_q + 32'd1;
                rr_q      <= rr_next;
            end
            if (state == S_RUN)
                fin_q <= fin_q | io_ch_finish;
            case (state)
                S_RUN: begin
                    if (timeout_hit)
                        state <= S_TIMEOUT;
                    else if (all_fin)
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (timeout_hit)
                        state <= S_TIMEOUT;
                    else if (empty && !(|io_ch_valid) && !push)
                        state <= S_DONE;
                end
                default: ;
            endcase
            if (can_start && io_start) begin
                state     <= S_RUN;
                total_q   <= '0;
                res_cnt_q <= '0;
                fin_q     <= '0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= {io_ch_ray_id[grant*DATA_W +: DATA_W],
                            io_ch_hitT[grant*DATA_W +: DATA_W], grant};
    end

    // Gate the head so every output reads zero while the FIFO is empty.
    assign head          = empty ? '0 : mem[rd_ptr];
    assign io_out_valid  = !empty;
    assign io_out_ray_id = head[EW-1 -: DATA_W];
    assign io_out_hitT   = head[CH_W +: DATA_W];
    assign io_out_ch     = head[CH_W-1:0];

    assign io_total_cycle  = total_q;
    assign io_result_count = res_cnt_q;
    assign io_busy         = active;
    assign io_all_done     = (state == S_DONE);
    assign io_timeout      = (state == S_TIMEOUT);

endmodule

// File: tb/tb_rtp_result_collector.sv
// Directed bench for rtp_result_collector.
// Two cores, 4-deep FIFO, 100-cycle watchdog.
module tb_rtp_result_collector;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_start;
    logic [1:0]  io_ch_valid;
    logic [1:0]  io_ch_ready;
    logic [63:0] io_ch_ray_id;
    logic [63:0] io_ch_hitT;
    logic [1:0]  io_ch_finish;
    logic        io_out_valid;
    logic        io_out_ready;
    logic [31:0] io_out_ray_id;
    logic [31:0] io_out_hitT;
    logic [0:0]  io_out_ch;
    logic [63:0] io_total_cycle;
    logic [31:0] io_result_count;
    logic        io_busy;
    logic        io_all_done;
    logic        io_timeout;

    int vectors = 0;
    int miscompares = 0;
    int run_cyc = 0;
    int k;
    bit exp_rdy [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    rtp_result_collector #(
        .NUM_CH(2), .DATA_W(32), .FIFO_DEPTH(4),
        .CNT_W(64), .TIMEOUT_CYCLES(100)
    ) dut (
        .clock(clock), .reset(reset), .io_start(io_start),
        .io_ch_valid(io_ch_valid), .io_ch_ready(io_ch_ready),
        .io_ch_ray_id(io_ch_ray_id), .io_ch_hitT(io_ch_hitT),
        .io_ch_finish(io_ch_finish), .io_out_valid(io_out_valid),
        .io_out_ready(io_out_ready), .io_out_ray_id(io_out_ray_id),
        .io_out_hitT(io_out_hitT), .io_out_ch(io_out_ch),
        .io_total_cycle(io_total_cycle),
        .io_result_count(io_result_count), .io_busy(io_busy),
        .io_all_done(io_all_done), .io_timeout(io_timeout)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
        run_cyc++;
    endtask

    task automatic start_run();
        io_start = 1'b1;
        tick();
        io_start = 1'b0;
        run_cyc = 0;
    endtask

    task automatic set_core(input int c, input logic [31:0] r,
                            input logic [31:0] h);
        io_ch_ray_id[c*32 +: 32] = r;
        io_ch_hitT[c*32 +: 32]   = h;
    endtask

    initial begin
        reset = 1'b1;
        io_start = 1'b0;
        io_ch_valid = '0;
        io_ch_ray_id = '0;
        io_ch_hitT = '0;
        io_ch_finish = '0;
        io_out_ready = 1'b0;
        tick();
        tick();
        chk("rst_valid", io_out_valid, 0);
        chk("rst_busy", io_busy, 0);
        chk("rst_total", io_total_cycle, 0);
        chk("rst_count", io_result_count, 0);
        chk("rst_ready", io_ch_ready, 0);
        chk("rst_flags", {io_all_done, io_timeout}, 0);
        reset = 1'b0;

        // Both cores always valid: grants alternate.
        io_out_ready = 1'b1;
        set_core(0, 32'hA0, 32'hA1);
        set_core(1, 32'hB0, 32'hB1);
        start_run();
        io_ch_valid = 2'b11;
        #1;
        for (int i = 0; i < 6; i++) begin
            chk("rr_ready", io_ch_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
            if (i > 0) begin
                chk("rr_valid", io_out_valid, 1);
                chk("rr_ch", io_out_ch, (i - 1) % 2);
                chk("rr_ray", io_out_ray_id,
                    ((i - 1) % 2 == 1) ? 32'hB0 : 32'hA0);
            end
            tick();
        end
        io_ch_valid = '0;
        #1;
        chk("rr_last_ch", io_out_ch, 1);
        chk("rr_count", io_result_count, 6);
        chk("rr_total", io_total_cycle, 6);
        io_ch_finish = 2'b11;
        tick();
        io_ch_finish = '0;
        chk("drain_busy", io_busy, 1);
        chk("drain_done", io_all_done, 0);
        chk("drain_empty", io_out_valid, 0);
        chk("drain_total", io_total_cycle, 7);
        tick();
        chk("done_flag", io_all_done, 1);
        chk("done_busy", io_busy, 0);
        chk("done_total", io_total_cycle, 8);
        tick();
        chk("done_hold", io_total_cycle, 8);

        // Fill the FIFO from core0 with the consumer stalled.
        io_out_ready = 1'b0;
        start_run();
        chk("b_total", io_total_cycle, 0);
        chk("b_count", io_result_count, 0);
        chk("b_busy", io_busy, 1);
        k = 0;
        for (int j = 0; j < 4; j++) begin
            io_ch_valid = 2'b01;
            set_core(0, 32'h10 + k, 32'h20 + k);
            #1;
            chk("fill_ready", io_ch_ready, 2'b01);
            tick();
            k++;
        end
        set_core(0, 32'h10 + k, 32'h20 + k);
        #1;
        chk("full_ready", io_ch_ready, 0);
        chk("full_count", io_result_count, 4);
        chk("full_head", io_out_ray_id, 32'h10);
        tick();
        chk("full_ready2", io_ch_ready, 0);
        io_out_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            io_ch_valid = (k < 6) ? 2'b01 : 2'b00;
            set_core(0, 32'h10 + k, 32'h20 + k);
            #1;
            chk("dr_ready", io_ch_ready, exp_rdy[j] ? 2'b01 : 2'b00);
            chk("dr_valid", io_out_valid, 1);
            chk("dr_ray", io_out_ray_id, 32'h10 + j);
            chk("dr_hit", io_out_hitT, 32'h20 + j);
            chk("dr_ch", io_out_ch, 0);
            tick();
            if (exp_rdy[j]) k++;
        end
        io_ch_valid = '0;
        #1;
        chk("dr_empty", io_out_valid, 0);
        chk("dr_count", io_result_count, 6);

        // Core1 never finishes: watchdog.
        io_ch_finish = 2'b01;
        tick();
        io_ch_finish = '0;
        while (run_cyc < 99) tick();
        chk("to_pre_total", io_total_cycle, 99);
        chk("to_pre_flag", io_timeout, 0);
        chk("to_pre_busy", io_busy, 1);
        tick();
        chk("to_flag", io_timeout, 1);
        chk("to_total", io_total_cycle, 100);
        chk("to_busy", io_busy, 0);
        tick();
        chk("to_hold", io_total_cycle, 100);
        start_run();
        chk("rs_total", io_total_cycle, 0);
        chk("rs_count", io_result_count, 0);
        chk("rs_flag", io_timeout, 0);
        chk("rs_busy", io_busy, 1);

        // Finishes at cycles 10 and 25.
        while (run_cyc < 26) begin
            io_ch_finish = (run_cyc == 10) ? 2'b01 :
                           (run_cyc == 25) ? 2'b10 : 2'b00;
            if (run_cyc == 20) begin
                chk("fin_mid_done", io_all_done, 0);
                chk("fin_mid_busy", io_busy, 1);
            end
            tick();
        end
        io_ch_finish = '0;
        chk("fin_drain_busy", io_busy, 1);
        chk("fin_drain_done", io_all_done, 0);
        chk("fin_drain_total", io_total_cycle, 26);
        tick();
        chk("fin_done", io_all_done, 1);
        chk("fin_total", io_total_cycle, 27);
        tick();
        chk("fin_hold", io_total_cycle, 27);

        // Last core finishes with a result in the same cycle.
        io_out_ready = 1'b0;
        start_run();
        io_ch_finish = 2'b01;
        tick();
        io_ch_finish = 2'b10;
        io_ch_valid = 2'b10;
        set_core(1, 32'h55, 32'h66);
        #1;
        chk("e_ready", io_ch_ready, 2'b10);
        tick();
        io_ch_finish = '0;
        io_ch_valid = '0;
        #1;
        chk("e_valid", io_out_valid, 1);
        chk("e_ch", io_out_ch, 1);
        chk("e_ray", io_out_ray_id, 32'h55);
        chk("e_count", io_result_count, 1);
        tick();
        tick();
        chk("e_wait_done", io_all_done, 0);
        chk("e_wait_busy", io_busy, 1);
        io_out_ready = 1'b1;
        tick();
        chk("e_popped", io_out_valid, 0);
        chk("e_pop_done", io_all_done, 0);
        tick();
        chk("e_done", io_all_done, 1);

        // Asynchronous reset between edges.
        io_out_ready = 1'b0;
        start_run();
        io_ch_valid = 2'b01;
        set_core(0, 32'h77, 32'h78);
        tick();
        tick();
        chk("f_valid", io_out_valid, 1);
        chk("f_count", io_result_count, 2);
        #2;
        reset = 1'b1;
        #1;
        chk("f_rst_valid", io_out_valid, 0);
        chk("f_rst_busy", io_busy, 0);
        chk("f_rst_total", io_total_cycle, 0);
        chk("f_rst_count", io_result_count, 0);
        chk("f_rst_ready", io_ch_ready, 0);
        chk("f_rst_ray", io_out_ray_id, 0);
        io_ch_valid = '0;
        tick();
        reset = 1'b0;
        chk("f_idle_valid", io_out_valid, 0);
        start_run();
        io_ch_valid = 2'b11;
        #1;
        chk("f_rr_ready", io_ch_ready, 2'b01);
        tick();
        io_ch_valid = '0;
        #1;
        chk("f_head_ch", io_out_ch, 0);
        chk("f_head_ray", io_out_ray_id, 32'h77);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
